consumer: RTL and testbench
===========================

# consumer

Receiving end of the producer's dual-channel address/ID stream. Accepts transfers on two independent channels, each with a stall back-pressure signal, buffers each channel in its own FIFO, and merges both into one output stream using round-robin arbitration. Sits directly downstream of `producer`; its stall outputs drive the producer's `in_stall_1`/`in_stall_2`.

## Interface
- `ADDR_W`, default `` `ADDRESS_WIDTH ``, address width
- `ID_W`, default `` `ID_WIDTH ``, ID width
- `DEPTH`, default 4, per-channel FIFO depth in entries; power of two, ≥2

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = in reset)
- `in_address_1`  in  ADDR_W  channel 1 address
- `in_id_1`  in  ID_W  channel 1 ID
- `in_valid_1`  in  1  channel 1 transfer request
- `out_stall_1`  out  1  channel 1 back-pressure
- `in_address_2`  in  ADDR_W  channel 2 address
- `in_id_2`  in  ID_W  channel 2 ID
- `in_valid_2`  in  1  channel 2 transfer request
- `out_stall_2`  out  1  channel 2 back-pressure
- `out_address`  out  ADDR_W  merged stream address
- `out_id`  out  ID_W  merged stream ID
- `out_channel`  out  1  source of current output: 0 = channel 1, 1 = channel 2
- `out_valid`  out  1  merged stream entry valid
- `in_ready`  in  1  downstream accepts the current entry

## Operation
- Input transfer on channel k: occurs at a rising edge where `in_valid_k`=1 and `out_stall_k`=0. The entry is pushed into FIFO k.
- While `out_stall_k`=1, `in_valid_k` and its data are ignored. The producer holds them until stall drops.
- `out_stall_k` = (count_k == DEPTH). It is a function of registered state only, with no combinational path from any input.
- Output pop: occurs at a rising edge where `out_valid`=1 and `in_ready`=1. Pops the granted FIFO.
- `out_valid` = either FIFO non-empty. `out_address`/`out_id`/`out_channel` come from the head of the granted FIFO.
- Arbitration:
  - Register `last` holds the last popped channel.
  - If exactly one FIFO is non-empty, grant it.
  - If both are non-empty, grant the channel ≠ `last`.
  - `last` updates only on a pop.
- Grant lock: while `out_valid`=1 and `in_ready`=0, the grant and output data are held stable, even if the other FIFO becomes non-empty. The lock releases on the pop.
- Push and pop on the same FIFO in the same cycle: count unchanged, both take effect.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Push on a full FIFO cannot occur (stall is asserted). Pop on an empty FIFO cannot occur (not granted).

## Timing
- Reset (asynchronous on assertion, released synchronously to `clk`):
  - Counts and pointers = 0.
  - `out_stall_1` = `out_stall_2` = 0, `out_valid` = 0.
  - `out_address`, `out_id`, `out_channel` = 0.
  - `last` = 1, so channel 1 wins the first tie.
  - Grant lock cleared.
- Reset mid-operation: all buffered entries are discarded immediately. No transfer is accepted while `reset`=0.
- Latency from input transfer at edge t to `out_valid`=1: visible after edge t (one cycle), provided the FIFO was empty and not locked to the other channel.
- Stall assertion: `out_stall_k` rises after the edge that makes count_k = DEPTH.
- Stall release: `out_stall_k` falls after the edge that pops from the full FIFO. The next push is accepted one edge later.
- Throughput: one push per channel per cycle, one pop per cycle total.

## Test plan
- Reset then single transfer:
  - Stimulus: with `in_ready`=1, ch1 sends addr 0x10, id 3 at cycle 0.
  - Response: `out_valid`=1, `out_address`=0x10, `out_id`=3, `out_channel`=0 in cycle 1; popped at the cycle-1 edge; `out_valid`=0 in cycle 2.
- Fill and stall:
  - Stimulus: `in_ready`=0, ch2 `in_valid` held high for 6 cycles, DEPTH=4.
  - Response: exactly 4 entries accepted; `out_stall_2`=1 from cycle 4.
  - Follow-up: raise `in_ready`. `out_stall_2` drops the cycle after the first pop, and the fifth entry is accepted the next edge.
- Round-robin:
  - Stimulus: preload ch1 with A0..A2 and ch2 with B0..B2, then set `in_ready`=1.
  - Response: output order A0, B0, A1, B1, A2, B2.
- Grant lock:
  - Stimulus: `in_ready`=0, ch2 entry presented (`out_channel`=1); ch1 then pushes while `last`=1.
  - Response: output stays on the ch2 entry until popped, then switches to ch1.
- Simultaneous push/pop at count 3 (DEPTH=4): count stays 3, `out_stall`=0, and data order is preserved across pointer wrap.
- Mid-operation reset:
  - Stimulus: assert `reset`=0 with both FIFOs partially full.
  - Response: `out_valid`, both stalls, and `out_channel` go to 0 without a clock edge. After release, no stale entries appear.

Source files
------------

// File: rtl/consumer.sv
// Dual-channel receiver: each input channel is buffered in its own FIFO and the two
// FIFOs are merged onto one output stream by round-robin arbitration with a grant lock.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module consumer #(
    parameter int ADDR_W = `ADDRESS_WIDTH,
    parameter int ID_W   = `ID_WIDTH,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_address_1,
    input  logic [ID_W-1:0]   in_id_1,
    input  logic              in_valid_1,
    output logic              out_stall_1,
    input  logic [ADDR_W-1:0] in_address_2,
    input  logic [ID_W-1:0]   in_id_2,
    input  logic              in_valid_2,
    output logic              out_stall_2,
    output logic [ADDR_W-1:0] out_address,
    output logic [ID_W-1:0]   out_id,
    output logic              out_channel,
    output logic              out_valid,
    input  logic              in_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_mem [2][DEPTH];
    logic [ID_W-1:0]   id_mem   [2][DEPTH];

    logic [PTR_W-1:0] wptr_q [2];
    logic [PTR_W-1:0] wptr_d [2];
    logic [PTR_W-1:0] rptr_q [2];
    logic [PTR_W-1:0] rptr_d [2];
    logic [CNT_W-1:0] cnt_q  [2];
    logic [CNT_W-1:0] cnt_d  [2];
    logic             last_q, last_d;
    logic             lock_q, lock_d;
    logic             lock_ch_q, lock_ch_d;

    logic [1:0]        in_valid;
    logic [ADDR_W-1:0] in_addr [2];
    logic [ID_W-1:0]   in_id   [2];
    logic [1:0]        nonempty;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic              grant;
    logic              pop_any;

    assign in_valid   = {in_valid_2, in_valid_1};
    assign in_addr[0] = in_address_1;
    assign in_addr[1] = in_address_2;
    assign in_id[0]   = in_id_1;
    assign in_id[1]   = in_id_2;

    // Stall depends on registered counts only, so the producer never sees a loop.
    assign out_stall_1 = (cnt_q[0] == FULL);
    assign out_stall_2 = (cnt_q[1] == FULL);

    always_comb begin
        nonempty = '0;
        push     = '0;
        for (int k = 0; k < 2; k++) begin
            nonempty[k] = (cnt_q[k] != '0);
            push[k]     = in_valid[k] & (cnt_q[k] != FULL);
        end

        // A presented-but-unaccepted entry keeps its grant until it is popped.
        if (lock_q)
            grant = lock_ch_q;
        else if (nonempty == 2'b11)
            grant = ~last_q;
        else
            grant = nonempty[1];

        pop_any = (|nonempty) & in_ready;
        pop     = '0;
        for (int k = 0; k < 2; k++) begin
            pop[k]    = pop_any & (grant == 1'(k));
            wptr_d[k] = wptr_q[k] + PTR_W'(push[k]);
            rptr_d[k] = rptr_q[k] + PTR_W'(pop[k]);
            cnt_d[k]  = cnt_q[k] + CNT_W'(push[k]) - CNT_W'(pop[k]);
        end

        last_d    = pop_any ? grant : last_q;
        lock_d    = (|nonempty) & ~in_ready;
        lock_ch_d = grant;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
            last_q    <= 1'b1;
            lock_q    <= 1'b0;
            lock_ch_q <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                wptr_q[k] <= wptr_d[k];
                rptr_q[k] <= rptr_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
            last_q    <= last_d;
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    // Storage needs no reset: counts gate every read.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (push[k]) begin
                addr_mem[k][wptr_q[k]] <= in_addr[k];
                id_mem[k][wptr_q[k]]   <= in_id[k];
            end
        end
    end

    assign out_valid   = |nonempty;
    assign out_channel = out_valid ? grant : 1'b0;
    assign out_address = out_valid ? addr_mem[grant][rptr_q[grant]] : '0;
    assign out_id      = out_valid ? id_mem[grant][rptr_q[grant]] : '0;

endmodule

// File: tb/tb_consumer.sv
// Directed bench for consumer: queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_consumer;
    localparam int AW    = 16;
    localparam int IW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] in_address_1, in_address_2;
    logic [IW-1:0] in_id_1, in_id_2;
    logic          in_valid_1, in_valid_2;
    logic          out_stall_1, out_stall_2;
    logic [AW-1:0] out_address;
    logic [IW-1:0] out_id;
    logic          out_channel;
    logic          out_valid;
    logic          in_ready;

    consumer #(.ADDR_W(AW), .ID_W(IW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_address_1 (in_address_1),
        .in_id_1      (in_id_1),
        .in_valid_1   (in_valid_1),
        .out_stall_1  (out_stall_1),
        .in_address_2 (in_address_2),
        .in_id_2      (in_id_2),
        .in_valid_2   (in_valid_2),
        .out_stall_2  (out_stall_2),
        .out_address  (out_address),
        .out_id       (out_id),
        .out_channel  (out_channel),
        .out_valid    (out_valid),
        .in_ready     (in_ready)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one queue per channel, plus the arbitration memory.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [IW-1:0] id;
    } ent_t;

    ent_t mq0[$];
    ent_t mq1[$];
    bit   m_last    = 1'b1;
    bit   m_hold    = 1'b0;
    bit   m_hold_ch = 1'b0;

    function automatic bit m_valid();
        return (mq0.size() != 0) || (mq1.size() != 0);
    endfunction

    function automatic bit m_grant();
        if (m_hold) return m_hold_ch;
        if (mq0.size() != 0 && mq1.size() != 0) return !m_last;
        return (mq1.size() != 0);
    endfunction

    always @(posedge clk or negedge reset) begin
        bit v, g, full0, full1;
        if (!reset) begin
            mq0.delete();
            mq1.delete();
            m_last = 1'b1;
            m_hold = 1'b0;
            m_hold_ch = 1'b0;
        end else begin
            v = m_valid();
            g = m_grant();
            full0 = (mq0.size() == DEPTH);
            full1 = (mq1.size() == DEPTH);
            if (v && in_ready) begin
                if (g) void'(mq1.pop_front());
                else   void'(mq0.pop_front());
                m_last = g;
            end
            if (in_valid_1 && !full0) mq0.push_back('{in_address_1, in_id_1});
            if (in_valid_2 && !full1) mq1.push_back('{in_address_2, in_id_2});
            m_hold    = v && !in_ready;
            m_hold_ch = g;
        end
    end

    logic [AW-1:0] pop_log[$];
    bit            log_en = 1'b0;

    always @(negedge clk) begin
        bit   v, g;
        ent_t e;
        v = m_valid();
        g = m_grant();
        e = '0;
        if (v) e = g ? mq1[0] : mq0[0];
        check("out_valid",   32'(out_valid),   32'(v));
        check("out_stall_1", 32'(out_stall_1), 32'(mq0.size() == DEPTH));
        check("out_stall_2", 32'(out_stall_2), 32'(mq1.size() == DEPTH));
        check("out_channel", 32'(out_channel), 32'(v ? g : 1'b0));
        check("out_address", 32'(out_address), 32'(e.a));
        check("out_id",      32'(out_id),      32'(e.id));
        if (log_en && out_valid && in_ready) pop_log.push_back(out_address);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [AW-1:0] rr_exp [6];
        int  k;
        bit  s;

        reset = 1'b0;
        in_address_1 = '0; in_id_1 = '0; in_valid_1 = 1'b0;
        in_address_2 = '0; in_id_2 = '0; in_valid_2 = 1'b0;
        in_ready = 1'b0;
        cyc(2);
        @(negedge clk);
        check("rst_valid",   32'(out_valid),   0);
        check("rst_stall_1", 32'(out_stall_1), 0);
        check("rst_stall_2", 32'(out_stall_2), 0);
        check("rst_addr",    32'(out_address), 0);
        cyc(1);
        reset = 1'b1;

        // Single transfer on channel 1
        in_ready = 1'b1;
        in_valid_1 = 1'b1; in_address_1 = 16'h0010; in_id_1 = 4'd3;
        cyc(1);
        in_valid_1 = 1'b0;
        @(negedge clk);
        check("t1_valid", 32'(out_valid),   1);
        check("t1_addr",  32'(out_address), 32'h10);
        check("t1_id",    32'(out_id),      3);
        check("t1_chan",  32'(out_channel), 0);
        cyc(1);
        @(negedge clk);
        check("t1_empty", 32'(out_valid), 0);

        // Fill channel 2 against a blocked output, producer-style hold on stall
        cyc(1);
        in_ready = 1'b0;
        k = 0;
        in_valid_2 = 1'b1; in_address_2 = 16'h0200; in_id_2 = 4'd0;
        for (int i = 0; i < 6; i++) begin
            s = out_stall_2;
            cyc(1);
            if (!s) k++;
            check("fill_stall", 32'(out_stall_2), 32'(i >= 3));
            in_address_2 = 16'h0200 + 16'(k);
            in_id_2 = 4'(k);
        end
        check("fill_accepted", 32'(k), 4);
        in_ready = 1'b1;
        s = out_stall_2;
        cyc(1);
        if (!s) k++;
        check("stall_release", 32'(out_stall_2), 0);
        check("no_push_on_pop", 32'(k), 4);
        s = out_stall_2;
        cyc(1);
        if (!s) k++;
        in_valid_2 = 1'b0;
        check("fifth_accepted", 32'(k), 5);
        cyc(6);

        // Round-robin between preloaded channels
        in_ready = 1'b0;
        in_valid_1 = 1'b1; in_valid_2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_address_1 = 16'h0100 + 16'(i); in_id_1 = 4'(i);
            in_address_2 = 16'h0300 + 16'(i); in_id_2 = 4'(i + 8);
            cyc(1);
        end
        in_valid_1 = 1'b0; in_valid_2 = 1'b0;
        pop_log.delete();
        log_en = 1'b1;
        in_ready = 1'b1;
        cyc(7);
        log_en = 1'b0;
        rr_exp = '{16'h0100, 16'h0300, 16'h0101, 16'h0301, 16'h0102, 16'h0302};
        check("rr_count", 32'(pop_log.size()), 6);
        for (int i = 0; i < 6; i++)
            if (i < pop_log.size()) check("rr_order", 32'(pop_log[i]), 32'(rr_exp[i]));

        // Grant lock: channel 2 held even though channel 1 would win the tie
        in_ready = 1'b0;
        in_valid_2 = 1'b1; in_address_2 = 16'h0400; in_id_2 = 4'd5;
        cyc(1);
        in_valid_2 = 1'b0;
        in_valid_1 = 1'b1; in_address_1 = 16'h0500; in_id_1 = 4'd6;
        cyc(1);
        in_valid_1 = 1'b0;
        cyc(1);
        @(negedge clk);
        check("lock_chan", 32'(out_channel), 1);
        check("lock_addr", 32'(out_address), 32'h400);
        in_ready = 1'b1;
        cyc(1);
        @(negedge clk);
        check("unlock_chan", 32'(out_channel), 0);
        check("unlock_addr", 32'(out_address), 32'h500);
        cyc(1);
        @(negedge clk);
        check("lock_drained", 32'(out_valid), 0);

        // Push and pop together at count 3, crossing the pointer wrap
        cyc(1);
        in_ready = 1'b0;
        in_valid_1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_address_1 = 16'h0600 + 16'(i); in_id_1 = 4'(i);
            cyc(1);
        end
        pop_log.delete();
        log_en = 1'b1;
        in_ready = 1'b1;
        for (int i = 3; i < 6; i++) begin
            in_address_1 = 16'h0600 + 16'(i); in_id_1 = 4'(i);
            cyc(1);
            check("pp_stall", 32'(out_stall_1), 0);
        end
        in_valid_1 = 1'b0;
        cyc(4);
        log_en = 1'b0;
        check("pp_count", 32'(pop_log.size()), 6);
        for (int i = 0; i < 6; i++)
            if (i < pop_log.size()) check("pp_order", 32'(pop_log[i]), 32'h600 + 32'(i));

        // Reset with data buffered and channel 1 full
        in_ready = 1'b0;
        in_valid_1 = 1'b1; in_valid_2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_address_1 = 16'h0800 + 16'(i);
            in_address_2 = 16'h0900 + 16'(i);
            cyc(1);
        end
        check("pre_rst_stall", 32'(out_stall_1), 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid",   32'(out_valid),   0);
        check("mid_rst_stall_1", 32'(out_stall_1), 0);
        check("mid_rst_stall_2", 32'(out_stall_2), 0);
        check("mid_rst_chan",    32'(out_channel), 0);
        cyc(3);
        reset = 1'b1;
        in_valid_1 = 1'b0; in_valid_2 = 1'b0;
        in_ready = 1'b1;
        cyc(3);
        @(negedge clk);
        check("post_rst_empty", 32'(out_valid), 0);
        in_valid_2 = 1'b1; in_address_2 = 16'h0A00; in_id_2 = 4'd7;
        cyc(1);
        in_valid_2 = 1'b0;
        @(negedge clk);
        check("post_rst_addr", 32'(out_address), 32'hA00);
        check("post_rst_chan", 32'(out_channel), 1);
        cyc(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
